// File: rtl/ntsc_sync_sep.sv
// ntsc_sync_sep -- sync separator and horizontal/vertical timing recoverer.
//
// Samples a composite video level and measures the width of every sync-tip
// pulse. Each pulse is classified as glitch, equalizing, horizontal sync,
// invalid or broad (vertical serration). Accepted hsyncs give a one-cycle
// h_pulse, the first broad pulse of a run gives a one-cycle v_pulse. Line and
// pixel position are tracked, and lock is declared after LOCK_LINES
// consecutive hsync-to-hsync periods inside [LINE_MIN, LINE_MAX].
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   v_data   in   video sample (DATA_BITS), synchronous to clk
//   h_pulse  out  one-cycle strobe per accepted hsync
//   v_pulse  out  one-cycle strobe at start of the vertical interval
//   line_num out  lines since last v_pulse, saturating at 1023
//   pixel_x  out  cycles since last h_pulse, saturating at 4095
//   field    out  toggles on every v_pulse
//   locked   out  horizontal timing locked
//
// Latency from a trailing edge on v_data to h_pulse/v_pulse is three clocks:
// input register, registered edge detect (with captured width), strobe
// register.

module ntsc_sync_sep #(
  parameter int DATA_BITS  = 4,
  parameter int SYNC_LEVEL = 0,
  parameter int MIN_EQ     = 80,
  parameter int MIN_HSYNC  = 175,
  parameter int MAX_HSYNC  = 300,
  parameter int MIN_BROAD  = 1000,
  parameter int LINE_MIN   = 3000,
  parameter int LINE_MAX   = 3350,
  parameter int LOCK_LINES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] v_data,
  output logic                 h_pulse,
  output logic                 v_pulse,
  output logic [9:0]           line_num,
  output logic [11:0]          pixel_x,
  output logic                 field,
  output logic                 locked
);

  localparam int GW = (LOCK_LINES < 2) ? 1 : $clog2(LOCK_LINES + 1);

  localparam logic [DATA_BITS-1:0] SYNC_LVL    = DATA_BITS'(SYNC_LEVEL);
  localparam logic [11:0]          MIN_EQ_W    = 12'(MIN_EQ);
  localparam logic [11:0]          MIN_HSYNC_W = 12'(MIN_HSYNC);
  localparam logic [11:0]          MAX_HSYNC_W = 12'(MAX_HSYNC);
  localparam logic [11:0]          MIN_BROAD_W = 12'(MIN_BROAD);
  localparam logic [11:0]          LINE_MIN_W  = 12'(LINE_MIN);
  localparam logic [11:0]          LINE_MAX_W  = 12'(LINE_MAX);
  localparam logic [11:0]          CNT12_MAX   = 12'hFFF;
  localparam logic [9:0]           LINE_SAT    = 10'h3FF;
  localparam logic [GW-1:0]        LOCK_N      = GW'(LOCK_LINES);
  localparam logic [GW-1:0]        GOOD_ONE    = GW'(1);
  localparam logic [GW-1:0]        GOOD_ZERO   = GW'(0);

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_GLITCH,
    CLS_EQ,
    CLS_HSYNC,
    CLS_INVALID,
    CLS_BROAD
  } cls_t;

  // Registers
  logic [DATA_BITS-1:0] v_q, v_d;
  logic                 sync_q, sync_d;
  logic [11:0]          w_q, w_d;
  logic                 trail_q, trail_d;
  logic [11:0]          wcap_q, wcap_d;
  logic [11:0]          pixel_x_q, pixel_x_d;
  logic [9:0]           line_num_q, line_num_d;
  logic                 field_q, field_d;
  logic                 locked_q, locked_d;
  logic [GW-1:0]        good_q, good_d;
  logic                 have_ref_q, have_ref_d;
  logic                 broad_run_q, broad_run_d;
  logic                 h_pulse_q, h_pulse_d;
  logic                 v_pulse_q, v_pulse_d;

  // Combinational helpers
  logic sync;
  cls_t cls;
  logic hs_accept;
  logic period_ok;

  assign sync = (v_q <= SYNC_LVL);

  // Front end: input register, sync delay, pulse width counter, edge capture.
  always_comb begin
    v_d    = v_data;
    sync_d = sync;
    w_d    = w_q;
    if (sync && !sync_q) begin
      w_d = 12'd1;
    end else if (sync && (w_q != CNT12_MAX)) begin
      w_d = w_q + 12'd1;
    end else begin
      w_d = w_q;
    end
    // The width is frozen at the trailing edge so classification can run a
    // cycle later even if a new pulse starts immediately.
    trail_d = sync_q & ~sync;
    if (trail_d) begin
      wcap_d = w_q;
    end else begin
      wcap_d = wcap_q;
    end
  end

  // Pulse classification from the captured width, valid only on trail_q.
  always_comb begin
    cls = CLS_NONE;
    if (trail_q) begin
      if (wcap_q < MIN_EQ_W) begin
        cls = CLS_GLITCH;
      end else if (wcap_q < MIN_HSYNC_W) begin
        cls = CLS_EQ;
      end else if (wcap_q <= MAX_HSYNC_W) begin
        cls = CLS_HSYNC;
      end else if (wcap_q < MIN_BROAD_W) begin
        cls = CLS_INVALID;
      end else begin
        cls = CLS_BROAD;
      end
    end else begin
      cls = CLS_NONE;
    end
  end

  assign hs_accept = (cls == CLS_HSYNC);
  assign period_ok = (pixel_x_q >= LINE_MIN_W) && (pixel_x_q <= LINE_MAX_W);

  // Timing state: strobes, position counters, lock qualification.
  always_comb begin
    h_pulse_d   = 1'b0;
    v_pulse_d   = 1'b0;
    pixel_x_d   = pixel_x_q;
    line_num_d  = line_num_q;
    field_d     = field_q;
    good_d      = good_q;
    have_ref_d  = have_ref_q;
    broad_run_d = broad_run_q;

    case (cls)
      CLS_EQ: begin
        broad_run_d = 1'b0;
      end
      CLS_HSYNC: begin
        broad_run_d = 1'b0;
        h_pulse_d   = 1'b1;
        if (line_num_q != LINE_SAT) begin
          line_num_d = line_num_q + 10'd1;
        end else begin
          line_num_d = line_num_q;
        end
        // The first hsync after reset or sync loss only sets the reference.
        if (!have_ref_q) begin
          have_ref_d = 1'b1;
        end else if (period_ok) begin
          if (good_q != LOCK_N) begin
            good_d = good_q + GOOD_ONE;
          end else begin
            good_d = good_q;
          end
        end else begin
          good_d = GOOD_ZERO;
        end
      end
      CLS_INVALID: begin
        good_d      = GOOD_ZERO;
        broad_run_d = 1'b0;
      end
      CLS_BROAD: begin
        // Only the first broad pulse of a run marks the vertical interval.
        if (!broad_run_q) begin
          v_pulse_d   = 1'b1;
          line_num_d  = 10'd0;
          field_d     = ~field_q;
          broad_run_d = 1'b1;
        end else begin
          broad_run_d = broad_run_q;
        end
      end
      default: begin
        broad_run_d = broad_run_q;
      end
    endcase

    // hsync clears pixel_x even when it coincides with saturation.
    if (hs_accept) begin
      pixel_x_d = 12'd0;
    end else if (pixel_x_q != CNT12_MAX) begin
      pixel_x_d = pixel_x_q + 12'd1;
    end else begin
      // No hsync for a full counter span: timing reference is lost.
      pixel_x_d  = pixel_x_q;
      good_d     = GOOD_ZERO;
      have_ref_d = 1'b0;
    end

    locked_d = (good_d == LOCK_N);
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q         <= {DATA_BITS{1'b1}};  // idle (non-sync) level
      sync_q      <= 1'b0;
      w_q         <= 12'd0;
      trail_q     <= 1'b0;
      wcap_q      <= 12'd0;
      pixel_x_q   <= 12'd0;
      line_num_q  <= 10'd0;
      field_q     <= 1'b0;
      locked_q    <= 1'b0;
      good_q      <= GOOD_ZERO;
      have_ref_q  <= 1'b0;
      broad_run_q <= 1'b0;
      h_pulse_q   <= 1'b0;
      v_pulse_q   <= 1'b0;
    end else begin
      v_q         <= v_d;
      sync_q      <= sync_d;
      w_q         <= w_d;
      trail_q     <= trail_d;
      wcap_q      <= wcap_d;
      pixel_x_q   <= pixel_x_d;
      line_num_q  <= line_num_d;
      field_q     <= field_d;
      locked_q    <= locked_d;
      good_q      <= good_d;
      have_ref_q  <= have_ref_d;
      broad_run_q <= broad_run_d;
      h_pulse_q   <= h_pulse_d;
      v_pulse_q   <= v_pulse_d;
    end
  end

  assign h_pulse  = h_pulse_q;
  assign v_pulse  = v_pulse_q;
  assign line_num = line_num_q;
  assign pixel_x  = pixel_x_q;
  assign field    = field_q;
  assign locked   = locked_q;

endmodule

// File: tb/tb_ntsc_sync_sep.sv
// Directed testbench for ntsc_sync_sep.
// Timing parameters are scaled to roughly a quarter of the defaults (same
// ordering and ratios) so the whole sequence stays short; the 12-bit counter
// saturation points are unchanged.

module tb_ntsc_sync_sep;

  localparam int P_MIN_EQ    = 20;
  localparam int P_MIN_HSYNC = 44;
  localparam int P_MAX_HSYNC = 75;
  localparam int P_MIN_BROAD = 250;
  localparam int P_LINE_MIN  = 750;
  localparam int P_LINE_MAX  = 838;
  localparam int P_LOCK      = 8;

  localparam int HS      = 59;   // nominal hsync width
  localparam int LINE    = 794;  // nominal line length -> measured period 793
  localparam int EQ_W    = 29;
  localparam int BROAD_W = 339;
  localparam int HALF    = 397;
  localparam int GLITCH  = 12;
  localparam int BAD_LEN = 625;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  v_data;
  logic        h_pulse;
  logic        v_pulse;
  logic [9:0]  line_num;
  logic [11:0] pixel_x;
  logic        field;
  logic        locked;

  int tests = 0;
  int fails = 0;
  int h_cnt = 0;
  int v_cnt = 0;
  int px_max = 0;
  int exp_h = 0;
  int exp_line = 0;

  ntsc_sync_sep #(
    .DATA_BITS (4),
    .SYNC_LEVEL(0),
    .MIN_EQ    (P_MIN_EQ),
    .MIN_HSYNC (P_MIN_HSYNC),
    .MAX_HSYNC (P_MAX_HSYNC),
    .MIN_BROAD (P_MIN_BROAD),
    .LINE_MIN  (P_LINE_MIN),
    .LINE_MAX  (P_LINE_MAX),
    .LOCK_LINES(P_LOCK)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .v_data  (v_data),
    .h_pulse (h_pulse),
    .v_pulse (v_pulse),
    .line_num(line_num),
    .pixel_x (pixel_x),
    .field   (field),
    .locked  (locked)
  );

  always #5 clk = ~clk;

  // Strobe counters and pixel_x peak, sampled on the inactive edge.
  always @(negedge clk) begin
    if (h_pulse === 1'b1) h_cnt++;
    if (v_pulse === 1'b1) v_cnt++;
    if (int'(pixel_x) > px_max) px_max = int'(pixel_x);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Hold v_data at val for n rising edges; returns 1 time unit after the last.
  task automatic cyc(input int n, input logic [3:0] val);
    v_data = val;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One line: sync tip of width w followed by blanking up to len cycles.
  task automatic hline(input int w, input int len);
    cyc(w, 4'h0);
    cyc(len - w, 4'hF);
  endtask

  initial begin
    // ---------------- reset state ----------------
    rst    = 1'b1;
    v_data = 4'hF;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("rst_h_pulse", h_pulse, 0);
    check("rst_v_pulse", v_pulse, 0);
    check("rst_line_num", line_num, 0);
    check("rst_pixel_x", pixel_x, 0);
    check("rst_field", field, 0);
    check("rst_locked", locked, 0);
    rst = 1'b0;

    // ---------------- first line: strobe latency ----------------
    cyc(HS, 4'h0);
    cyc(2, 4'hF);
    check("lat_h_early", h_pulse, 0);
    cyc(1, 4'hF);
    check("lat_h_on", h_pulse, 1);
    check("lat_pixel_clr", pixel_x, 0);
    check("lat_line1", line_num, 1);
    check("lat_unlocked", locked, 0);
    cyc(1, 4'hF);
    check("lat_h_one_cycle", h_pulse, 0);
    check("lat_pixel_1", pixel_x, 1);
    cyc(LINE - HS - 4, 4'hF);
    exp_h = 1; exp_line = 1;
    check("line_end_pixel", pixel_x, 732);

    // ---------------- lines 2..12 ----------------
    for (int i = 2; i <= 12; i++) begin
      hline(HS, LINE);
      exp_h++; exp_line++;
      if (i == 8) check("lock_after_8", locked, 0);
      if (i == 9) check("lock_after_9", locked, 1);
    end
    check("h_count_12", h_cnt, exp_h);
    check("locked_12", locked, 1);
    check("pixel_peak", px_max, LINE - 1);
    check("line_num_12", line_num, exp_line);
    check("v_none_yet", v_cnt, 0);

    // ---------------- glitch mid-line ----------------
    cyc(HS, 4'h0);
    cyc(250, 4'hF);
    cyc(GLITCH, 4'h0);
    cyc(10, 4'hF);
    exp_h++; exp_line++;
    check("glitch_no_h", h_cnt, exp_h);
    check("glitch_pixel", pixel_x, 269);
    check("glitch_locked", locked, 1);
    cyc(LINE - HS - 250 - GLITCH - 10, 4'hF);
    hline(HS, LINE);
    exp_h++; exp_line++;
    check("glitch_next_locked", locked, 1);
    check("glitch_next_h", h_cnt, exp_h);

    // ---------------- width boundaries ----------------
    cyc(HS, 4'h0);
    cyc(300, 4'hF);
    cyc(P_MIN_HSYNC - 1, 4'h0);   // equalizing, no strobe
    cyc(LINE - HS - 300 - (P_MIN_HSYNC - 1), 4'hF);
    exp_h++; exp_line++;
    check("eq_no_h", h_cnt, exp_h);
    check("eq_no_line", line_num, exp_line);
    check("eq_locked", locked, 1);
    hline(P_MIN_HSYNC, LINE);
    exp_h++; exp_line++;
    check("hs_min_width", h_cnt, exp_h);
    hline(P_MAX_HSYNC, LINE);
    exp_h++; exp_line++;
    check("hs_max_width", h_cnt, exp_h);
    check("hs_width_locked", locked, 1);

    // ---------------- short period drops lock, then relock ----------------
    hline(HS, BAD_LEN);
    exp_h++; exp_line++;
    check("bad_pre_locked", locked, 1);
    hline(HS, LINE);
    exp_h++; exp_line++;
    check("bad_unlocked", locked, 0);
    check("bad_h", h_cnt, exp_h);
    for (int j = 1; j <= 8; j++) begin
      // Lines of 751 and 839 cycles measure exactly LINE_MIN and LINE_MAX.
      hline(HS, (j == 1) ? (P_LINE_MIN + 1) : ((j == 2) ? (P_LINE_MAX + 1) : LINE));
      exp_h++; exp_line++;
      if (j == 7) check("relock_7", locked, 0);
      if (j == 8) check("relock_8", locked, 1);
    end

    // ---------------- constant sync level ----------------
    cyc(1000, 4'h0);
    check("const_mid_locked", locked, 1);
    check("const_mid_pixel", pixel_x, 1732);
    cyc(4000, 4'h0);
    check("const_pixel_sat", pixel_x, 4095);
    check("const_unlocked", locked, 0);
    check("const_no_h", h_cnt, exp_h);
    check("const_no_v", v_cnt, 0);
    // Releasing after a saturated width is a broad pulse.
    cyc(2000, 4'hF);
    exp_line = 0;
    check("const_release_v", v_cnt, 1);
    check("const_release_field", field, 1);
    check("const_release_line", line_num, 0);
    for (int j = 1; j <= 9; j++) begin
      hline(HS, LINE);
      exp_h++; exp_line++;
      if (j == 8) check("const_relock_8", locked, 0);
      if (j == 9) check("const_relock_9", locked, 1);
    end
    check("const_relock_line", line_num, exp_line);

    // ---------------- reset mid-line ----------------
    cyc(HS, 4'h0);
    cyc(300, 4'hF);
    exp_h++;
    rst = 1'b1;
    #1;
    check("mrst_h_pulse", h_pulse, 0);
    check("mrst_v_pulse", v_pulse, 0);
    check("mrst_line_num", line_num, 0);
    check("mrst_pixel_x", pixel_x, 0);
    check("mrst_field", field, 0);
    check("mrst_locked", locked, 0);
    cyc(3, 4'hF);
    rst = 1'b0;
    exp_line = 0;
    cyc(LINE - HS - 303, 4'hF);
    for (int j = 1; j <= 9; j++) begin
      hline(HS, LINE);
      exp_h++; exp_line++;
      if (j == 1) check("mrst_first_h", h_cnt, exp_h);
      if (j == 1) check("mrst_first_unlocked", locked, 0);
      if (j == 8) check("mrst_lock_8", locked, 0);
      if (j == 9) check("mrst_lock_9", locked, 1);
    end
    check("mrst_line_num9", line_num, exp_line);

    // ---------------- invalid width drops lock ----------------
    cyc(P_MAX_HSYNC + 1, 4'h0);
    cyc(2, 4'hF);
    check("inv_locked_before", locked, 1);
    cyc(1, 4'hF);
    check("inv_locked_after", locked, 0);
    cyc(LINE - (P_MAX_HSYNC + 1) - 3, 4'hF);
    check("inv_no_h", h_cnt, exp_h);
    check("inv_line_hold", line_num, exp_line);

    // ---------------- vertical interval ----------------
    for (int k = 0; k < 6; k++) begin
      cyc(EQ_W, 4'h0);
      cyc(HALF - EQ_W, 4'hF);
    end
    check("vi_eq_no_line", line_num, exp_line);
    cyc(BROAD_W, 4'h0);
    cyc(2, 4'hF);
    check("vi_v_early", v_pulse, 0);
    cyc(1, 4'hF);
    check("vi_v_on", v_pulse, 1);
    check("vi_line_zero", line_num, 0);
    check("vi_field", field, 1);
    cyc(HALF - BROAD_W - 3, 4'hF);
    for (int k = 1; k < 6; k++) begin
      cyc(BROAD_W, 4'h0);
      cyc(HALF - BROAD_W, 4'hF);
    end
    for (int k = 0; k < 6; k++) begin
      cyc(EQ_W, 4'h0);
      cyc(HALF - EQ_W, 4'hF);
    end
    check("vi_one_v", v_cnt, 2);
    check("vi_no_h", h_cnt, exp_h);
    check("vi_field_once", field, 1);
    check("vi_line_still_0", line_num, 0);
    hline(HS, LINE);
    exp_h++;
    check("vi_line_1", line_num, 1);
    hline(HS, LINE);
    exp_h++;
    check("vi_line_2", line_num, 2);
    check("vi_h_total", h_cnt, exp_h);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ntsc_sync_sep.md
Name: ntsc_sync_sep

Overview:
- Sync separator and timing recoverer for the composite video stream that ntsc_gen produces.
- Samples the DATA_BITS-wide video level and classifies sync-tip pulses by width: equalizing, horizontal, broad/vertical.
- Outputs one-cycle line and frame strobes, line/pixel position and a lock flag.
- Used for on-chip loopback checking of the video generator, and as the front end of a future capture path.

Parameters:
- DATA_BITS, 4, width of video sample input.
- SYNC_LEVEL, 0, samples <= this value are sync tip.
- MIN_EQ, 80, minimum width (cycles) of any accepted pulse; shorter = glitch.
- MIN_HSYNC, 175, minimum width of horizontal sync.
- MAX_HSYNC, 300, maximum width of horizontal sync.
- MIN_BROAD, 1000, minimum width of broad (vertical serration) pulse.
- LINE_MIN, 3000, minimum valid hsync-to-hsync period (cycles).
- LINE_MAX, 3350, maximum valid hsync-to-hsync period.
- LOCK_LINES, 8, consecutive valid periods required for lock.

Ports:
- clk, in, 1, system clock (50 MHz).
- rst, in, 1, asynchronous active-high reset.
- v_data, in, DATA_BITS, video sample, synchronous to clk.
- h_pulse, out, 1, one-cycle strobe per accepted hsync.
- v_pulse, out, 1, one-cycle strobe at start of vertical interval.
- line_num, out, 10, lines since last v_pulse, saturating at 1023.
- pixel_x, out, 12, cycles since last h_pulse, saturating at 4095.
- field, out, 1, toggles on every v_pulse.
- locked, out, 1, horizontal timing locked.

Behaviour:
- Reset: all outputs 0; width counter, good-line counter, have_ref flag, sync_q all 0.
- v_data registered once into v_q; sync = (v_q <= SYNC_LEVEL); sync_q is sync delayed one cycle.
- Width counter w:
  - increments while sync = 1, saturating at 4095;
  - cleared to 1 on a sync rising edge.
- Classification happens on the trailing edge (sync_q = 1, sync = 0), using w:
  - w < MIN_EQ: glitch, ignored entirely, no state change.
  - MIN_EQ <= w < MIN_HSYNC: equalizing; no strobe; broad-run counter cleared.
  - MIN_HSYNC <= w <= MAX_HSYNC: hsync; broad-run counter cleared.
  - MAX_HSYNC < w < MIN_BROAD: invalid; good-line counter cleared, locked drops next cycle.
  - w >= MIN_BROAD: broad.
- hsync accepted (registered; strobe in the cycle after the trailing-edge cycle):
  - h_pulse = 1 for exactly one cycle; pixel_x <= 0; line_num <= line_num + 1 (saturate).
  - If have_ref = 0: have_ref <= 1, no period check.
  - Else period = pixel_x value before clear.
    - If LINE_MIN <= period <= LINE_MAX: good counter increments, saturating at LOCK_LINES.
    - Otherwise good counter <= 0.
- locked = (good counter == LOCK_LINES), registered.
- pixel_x increments every cycle otherwise, saturating at 4095.
  - If pixel_x reaches 4095 (sync lost): good counter <= 0 and have_ref <= 0.
- Broad run:
  - The first broad pulse after any non-broad classification asserts v_pulse for one cycle, same timing as h_pulse.
  - On that pulse: line_num <= 0, field toggles.
  - Subsequent broad pulses in the same run do not re-strobe.
- Simultaneous hsync accept and pixel_x saturation: the hsync action wins (pixel_x <= 0).
- Constant sync level (w saturated, no trailing edge): no strobes; lock drops via pixel_x saturation.
- Reset asserted mid-line: immediate clear. After release, LOCK_LINES+1 valid hsyncs are required before locked = 1.
- Latency: trailing edge on v_data to h_pulse/v_pulse = 3 clk (input reg, edge detect, strobe reg).

Test Plan:
- 12 lines: hsync width 235, period 3175 -> h_pulse once per line, 3 cycles after each trailing edge. locked rises after the 9th hsync and stays 1. pixel_x peaks at 3174.
- Inject a 50-cycle sync glitch mid-line while locked -> no h_pulse, pixel_x and locked unchanged.
- While locked, one line with period 2500 -> good counter cleared, locked = 0 after that h_pulse. Relock after 8 further valid periods.
- Vertical interval: 6 equalizing (115), 6 broad (1355), 6 equalizing at half-line spacing, then normal lines -> exactly one v_pulse (at 1st broad trailing edge). line_num = 0 then counts 1, 2, ... per hsync. field toggles once. Equalizing pulses do not increment line_num.
- Hold v_data = 0 for 5000 cycles while locked -> no strobes, w saturates, locked = 0 once pixel_x hits 4095.
- Assert rst for 3 cycles mid-line while locked -> all outputs 0 immediately. The first post-reset hsync gives h_pulse but no lock credit; locked returns only after the 9th hsync.
